// File: rtl/cpu_sdram_bridge_pkg.sv
// rtl/cpu_sdram_bridge_pkg.sv - shared state, size and cpustate encodings for the CPU SDRAM bridge
package cpu_sdram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WORD0,
        ST_GAP,
        ST_WORD1,
        ST_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] CS_FETCH = 2'b00;
    localparam logic [1:0] CS_IDLE  = 2'b01;
    localparam logic [1:0] CS_READ  = 2'b10;
    localparam logic [1:0] CS_WRITE = 2'b11;

    // Reserved size, or a word/long on an odd byte address, never reaches SDRAM.
    function automatic logic req_bad(input logic [1:0] size, input logic addr0);
        return (size == SZ_RSVD) || ((size != SZ_BYTE) && addr0);
    endfunction

endpackage

// File: rtl/cpu_sdram_bridge_lanes.sv
// rtl/cpu_sdram_bridge_lanes.sv - byte-strobe and write-data steering plus read-data alignment
module cpu_sdram_bridge_lanes
    import cpu_sdram_bridge_pkg::*;
(
    input  logic        active,
    input  logic        we,
    input  logic        addr0,
    input  logic        second,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [15:0] hi,
    input  logic [15:0] lo,
    output logic        cpu_l,
    output logic        cpu_u,
    output logic [15:0] wr,
    output logic [31:0] rdata
);

    // Big-endian bus: an even byte address lives in the upper lane.
    always_comb begin
        cpu_l = 1'b1;
        cpu_u = 1'b1;
        wr    = '0;
        if (active) begin
            if (size == SZ_BYTE) begin
                if (addr0) begin
                    cpu_l = 1'b0;
                    if (we) wr[7:0] = wdata[7:0];
                end else begin
                    cpu_u = 1'b0;
                    if (we) wr[15:8] = wdata[7:0];
                end
            end else begin
                cpu_l = 1'b0;
                cpu_u = 1'b0;
                if (we) wr = (size == SZ_LONG && !second) ? wdata[31:16] : wdata[15:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (size)
            SZ_BYTE: rdata[7:0]  = addr0 ? hi[7:0] : hi[15:8];
            SZ_WORD: rdata[15:0] = hi;
            SZ_LONG: rdata       = {hi, lo};
            default: rdata       = '0;
        endcase
    end

endmodule

// File: rtl/cpu_sdram_bridge.sv
// rtl/cpu_sdram_bridge.sv - request/response front end for the sdram_ctrl CPU port; optional watchdog via CPU_SDRAM_BRIDGE_TIMEOUT_EN
module cpu_sdram_bridge
    import cpu_sdram_bridge_pkg::*;
#(
    parameter int addr_bits      = 25,
    parameter int gap_cycles     = 3,
    parameter int timeout_cycles = 1024
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic                 req_fetch,
    input  logic [1:0]           req_size,
    input  logic [addr_bits:0]   req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [addr_bits-1:0] cpuAddr,
    output logic [3:0]           cpustate,
    output logic                 cpuL,
    output logic                 cpuU,
    output logic [15:0]          cpuWR,
    input  logic [15:0]          cpuRD,
    input  logic                 cpuena
);

    localparam int ADDR_W = addr_bits + 1;

    state_t             state, state_nx;
    logic               we_q, fetch_q, err_q, second_q;
    logic [1:0]         size_q;
    logic [addr_bits:0] addr_q;
    logic [31:0]        wdata_q;
    logic [15:0]        hi_q, lo_q;
    logic [3:0]         gap_cnt;
    logic               accept, in_word, word_done, timed_out;
    logic [31:0]        rdata_al;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_word   = (state == ST_WORD0) || (state == ST_WORD1);
    assign word_done = in_word && cpuena;

`ifdef CPU_SDRAM_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(timeout_cycles + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n)              to_cnt <= '0;
        else if (!in_word || cpuena) to_cnt <= '0;
        else                       to_cnt <= to_cnt + 1'b1;
    end

    assign timed_out = in_word && !cpuena && (to_cnt == TW'(timeout_cycles - 1));
`else
    // Without the watchdog the bridge waits on cpuena forever.
    assign timed_out = (timeout_cycles < 0);
`endif

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cpustate = {1'b0, 1'b1, CS_IDLE};
        case (state)
            ST_IDLE:
                if (accept) state_nx = req_bad(req_size, req_addr[0]) ? ST_RESP : ST_WORD0;
            ST_WORD0, ST_WORD1: begin
                cpustate[3]   = (size_q == SZ_LONG);
                cpustate[2]   = 1'b0;
                cpustate[1:0] = we_q ? CS_WRITE : (fetch_q ? CS_FETCH : CS_READ);
                if (word_done || timed_out) state_nx = ST_GAP;
            end
            ST_GAP:
                if (gap_cnt == 4'd0)
                    state_nx = (size_q == SZ_LONG && !second_q && !err_q) ? ST_WORD1 : ST_RESP;
            ST_RESP:
                state_nx = ST_IDLE;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            fetch_q  <= 1'b0;
            err_q    <= 1'b0;
            second_q <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            gap_cnt  <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                fetch_q  <= req_fetch && !req_we;
                err_q    <= req_bad(req_size, req_addr[0]);
                second_q <= 1'b0;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                hi_q     <= '0;
                lo_q     <= '0;
            end
            if (word_done) begin
                if (state == ST_WORD0) hi_q <= cpuRD;
                else                   lo_q <= cpuRD;
            end
            if (timed_out) err_q <= 1'b1;
            if (state_nx == ST_GAP && state != ST_GAP) gap_cnt <= 4'(gap_cycles - 1);
            else if (gap_cnt != 4'd0)                  gap_cnt <= gap_cnt - 4'd1;
            // The low half of a long sits at addr+2, wrapping across the top of memory.
            if (state == ST_GAP && state_nx == ST_WORD1) begin
                second_q <= 1'b1;
                addr_q   <= addr_q + ADDR_W'(2);
            end
        end
    end

    cpu_sdram_bridge_lanes u_lanes (
        .active (in_word),
        .we     (we_q),
        .addr0  (addr_q[0]),
        .second (second_q),
        .size   (size_q),
        .wdata  (wdata_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .cpu_l  (cpuL),
        .cpu_u  (cpuU),
        .wr     (cpuWR),
        .rdata  (rdata_al)
    );

    assign cpuAddr   = addr_q[addr_bits:1];
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? rdata_al : '0;

endmodule
